pipeline_hazard_ctrl: RTL

//  Hazard/sequencing controller for the 5-stage RV64 pipeline. Drives IF/ID stall+flush, PC write enable,
//  ID/EX bubble/hold and EX kill. Handles load-use stalls, multi-cycle EX ops and taken-branch redirects.

---
 rtl/pipeline_hazard_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use stalls, multi-cycle EX ops, branch redirects.
// Optional perf counters are enabled by defining HAZ_PERF_EN.
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_AW    = 5,
    parameter int unsigned MULTI_LAT = 4,
    parameter int unsigned CNT_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs2,
    input  logic              ex_valid,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_multi,
    input  logic              branch_taken,
    output logic              pc_write,
    output logic              if_id_stall,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic              id_ex_hold,
    output logic              ex_kill,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_events
);

    localparam int unsigned CW = (MULTI_LAT > 2) ? $clog2(MULTI_LAT) : 1;
    localparam logic [CW-1:0] MC_INIT = CW'(MULTI_LAT - 2);

    typedef enum logic [1:0] {RUN, MC_BUSY, REDIRECT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] mc_cnt_q, mc_cnt_d;
    logic          lu;

    assign lu = id_valid & ex_valid & ex_mem_read & (ex_rd != '0) &
                ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));

    always_comb begin
        state_d      = state_q;
        mc_cnt_d     = mc_cnt_q;
        pc_write     = 1'b1;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        id_ex_hold   = 1'b0;
        ex_kill      = 1'b0;
        if (reset) begin
            pc_write = 1'b0;
            state_d  = RUN;
            mc_cnt_d = '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (branch_taken) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                        state_d      = REDIRECT;
                    end else if (ex_valid && ex_multi) begin
                        pc_write    = 1'b0;
                        if_id_stall = 1'b1;
                        id_ex_hold  = 1'b1;
                        mc_cnt_d    = MC_INIT;
                        state_d     = MC_BUSY;
                    end else if (lu) begin
                        pc_write     = 1'b0;
                        if_id_stall  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end
                end
                MC_BUSY: begin
                    // The redirecting branch is older than the multi-cycle op, so the op is squashed.
                    if (branch_taken) begin
                        ex_kill      = 1'b1;
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                        state_d      = REDIRECT;
                    end else if (mc_cnt_q != '0) begin
                        pc_write    = 1'b0;
                        if_id_stall = 1'b1;
                        id_ex_hold  = 1'b1;
                        mc_cnt_d    = mc_cnt_q - 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
                REDIRECT: begin
                    if_id_flush = 1'b1;
                    if (branch_taken) begin
                        id_ex_bubble = 1'b1;
                        state_d      = REDIRECT;
                    end else begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RUN;
            mc_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            mc_cnt_q <= mc_cnt_d;
        end
    end

`ifdef HAZ_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!pc_write && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (if_id_flush && branch_taken && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_events = flush_cnt_q;
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule
